// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: funct3 encodings, error codes,
// FSM state encoding and the access legality check.
`timescale 1ns/1ps
package dmem_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam logic [3:0] ERR_LD_MISALIGN = 4'd0;
  localparam logic [3:0] ERR_ST_MISALIGN = 4'd1;
  localparam logic [3:0] ERR_ILLEGAL     = 4'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef struct packed {
    logic       err;
    logic [3:0] code;
  } chk_t;

  // Misalignment is reported ahead of funct3 legality when both apply.
  function automatic chk_t access_check(input logic rw, input logic [2:0] funct3,
                                        input logic [31:0] addr);
    chk_t r;
    r.err  = 1'b0;
    r.code = ERR_LD_MISALIGN;
    if ((funct3 == LW) && (addr[1:0] != 2'b00)) begin
      r.err  = 1'b1;
      r.code = rw ? ERR_ST_MISALIGN : ERR_LD_MISALIGN;
    end else if (((funct3 == LH) || (funct3 == LHU)) && addr[0]) begin
      r.err  = 1'b1;
      r.code = rw ? ERR_ST_MISALIGN : ERR_LD_MISALIGN;
    end else if (rw && !((funct3 == SB) || (funct3 == SH) || (funct3 == SW))) begin
      r.err  = 1'b1;
      r.code = ERR_ILLEGAL;
    end else if (!rw && ((funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111))) begin
      r.err  = 1'b1;
      r.code = ERR_ILLEGAL;
    end else begin
      r.err  = 1'b0;
      r.code = ERR_LD_MISALIGN;
    end
    return r;
  endfunction

endpackage

// File: rtl/dmem_arb_grant.sv
// Grant selection for the two requesters: fixed priority with a starvation
// counter, or round-robin when DMEM_ARB_ROUND_ROBIN_EN is defined.
`timescale 1ns/1ps
module dmem_arb_grant
  import dmem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic accept_en,
  input  logic req0_valid,
  input  logic req1_valid,
  output logic gnt0,
  output logic gnt1
);

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic last_q;
  logic last_d;

  // Round-robin choice; the pointer remembers the port granted last.
  always_comb begin
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    last_d = last_q;
    if (accept_en) begin
      if (req0_valid && req1_valid) begin
        if (last_q) begin
          gnt0 = 1'b1;
        end else begin
          gnt1 = 1'b1;
        end
      end else if (req0_valid) begin
        gnt0 = 1'b1;
      end else if (req1_valid) begin
        gnt1 = 1'b1;
      end else begin
        gnt0 = 1'b0;
      end
      if (gnt0) begin
        last_d = 1'b0;
      end else if (gnt1) begin
        last_d = 1'b1;
      end else begin
        last_d = last_q;
      end
    end else begin
      last_d = last_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b0;
    end else begin
      last_q <= last_d;
    end
  end
`else
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             force1_s;

  // Port 0 wins unless port 1 has watched STARVE_LIMIT port-0 grants go by.
  always_comb begin
    force1_s = (cnt_q >= CNT_W'(STARVE_LIMIT));
    gnt1     = accept_en & req1_valid & (~req0_valid | force1_s);
    gnt0     = accept_en & req0_valid & ~gnt1;
    if (!req1_valid) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (gnt1) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (gnt0) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port request sequencer in front of the single-port data memory.
// Arbitration mode is selected by DMEM_ARB_ROUND_ROBIN_EN (see dmem_arb_grant).
`timescale 1ns/1ps
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_rw,
  input  logic [2:0]  req0_funct3,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_rw,
  input  logic [2:0]  req1_funct3,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_rdata,
  output logic        rsp0_err,
  output logic [3:0]  rsp0_err_code,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_rdata,
  output logic        rsp1_err,
  output logic [3:0]  rsp1_err_code,
  output logic        mem_rw,
  output logic [2:0]  mem_funct3,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_e      state_q, state_d;
  logic        lat_rw_q, lat_rw_d;
  logic [2:0]  lat_f3_q, lat_f3_d;
  logic [31:0] lat_addr_q, lat_addr_d;
  logic [31:0] lat_wdata_q, lat_wdata_d;
  logic        lat_port_q, lat_port_d;
  logic        rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
  logic [31:0] rsp0_rdata_q, rsp0_rdata_d, rsp1_rdata_q, rsp1_rdata_d;
  logic        rsp0_err_q, rsp0_err_d, rsp1_err_q, rsp1_err_d;
  logic [3:0]  rsp0_code_q, rsp0_code_d, rsp1_code_q, rsp1_code_d;

  logic        gnt0_s, gnt1_s, accept_en_s;
  logic        inc_rw_s;
  logic [2:0]  inc_f3_s;
  logic [31:0] inc_addr_s, inc_wdata_s;
  chk_t        chk_s;
  logic        rsp_valid_s, rsp_port_s, rsp_err_s;
  logic [31:0] rsp_rdata_s;
  logic [3:0]  rsp_code_s;

  assign accept_en_s = (state_q == IDLE) & ~rst;

  dmem_arb_grant #(
    .STARVE_LIMIT(STARVE_LIMIT),
    .CNT_W       (CNT_W)
  ) u_grant (
    .clk       (clk),
    .rst       (rst),
    .accept_en (accept_en_s),
    .req0_valid(req0_valid),
    .req1_valid(req1_valid),
    .gnt0      (gnt0_s),
    .gnt1      (gnt1_s)
  );

  assign req0_ready = gnt0_s;
  assign req1_ready = gnt1_s;

  // Next-state, request latch and response computation.
  always_comb begin
    inc_rw_s    = gnt1_s ? req1_rw     : req0_rw;
    inc_f3_s    = gnt1_s ? req1_funct3 : req0_funct3;
    inc_addr_s  = gnt1_s ? req1_addr   : req0_addr;
    inc_wdata_s = gnt1_s ? req1_wdata  : req0_wdata;
    chk_s       = access_check(inc_rw_s, inc_f3_s, inc_addr_s);

    state_d     = state_q;
    lat_rw_d    = lat_rw_q;
    lat_f3_d    = lat_f3_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    lat_port_d  = lat_port_q;
    rsp_valid_s = 1'b0;
    rsp_port_s  = lat_port_q;
    rsp_rdata_s = 32'd0;
    rsp_err_s   = 1'b0;
    rsp_code_s  = 4'd0;

    case (state_q)
      IDLE: begin
        if (gnt0_s || gnt1_s) begin
          lat_rw_d    = inc_rw_s;
          lat_f3_d    = inc_f3_s;
          lat_addr_d  = inc_addr_s;
          lat_wdata_d = inc_wdata_s;
          lat_port_d  = gnt1_s;
          if (chk_s.err) begin
            state_d     = RESP;
            rsp_valid_s = 1'b1;
            rsp_port_s  = gnt1_s;
            rsp_err_s   = 1'b1;
            rsp_code_s  = chk_s.code;
          end else begin
            state_d = ACCESS;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        state_d     = RESP;
        rsp_valid_s = 1'b1;
        rsp_port_s  = lat_port_q;
        rsp_rdata_s = lat_rw_q ? 32'd0 : mem_rdata;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    rsp0_valid_d = rsp_valid_s & ~rsp_port_s;
    rsp1_valid_d = rsp_valid_s &  rsp_port_s;
    rsp0_rdata_d = rsp0_valid_d ? rsp_rdata_s : 32'd0;
    rsp1_rdata_d = rsp1_valid_d ? rsp_rdata_s : 32'd0;
    rsp0_err_d   = rsp0_valid_d & rsp_err_s;
    rsp1_err_d   = rsp1_valid_d & rsp_err_s;
    rsp0_code_d  = rsp0_valid_d ? rsp_code_s : 4'd0;
    rsp1_code_d  = rsp1_valid_d ? rsp_code_s : 4'd0;
  end

  // FSM, request latch and registered responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      lat_rw_q     <= 1'b0;
      lat_f3_q     <= 3'd0;
      lat_addr_q   <= 32'd0;
      lat_wdata_q  <= 32'd0;
      lat_port_q   <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp0_rdata_q <= 32'd0;
      rsp0_err_q   <= 1'b0;
      rsp0_code_q  <= 4'd0;
      rsp1_valid_q <= 1'b0;
      rsp1_rdata_q <= 32'd0;
      rsp1_err_q   <= 1'b0;
      rsp1_code_q  <= 4'd0;
    end else begin
      state_q      <= state_d;
      lat_rw_q     <= lat_rw_d;
      lat_f3_q     <= lat_f3_d;
      lat_addr_q   <= lat_addr_d;
      lat_wdata_q  <= lat_wdata_d;
      lat_port_q   <= lat_port_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp0_rdata_q <= rsp0_rdata_d;
      rsp0_err_q   <= rsp0_err_d;
      rsp0_code_q  <= rsp0_code_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp1_rdata_q <= rsp1_rdata_d;
      rsp1_err_q   <= rsp1_err_d;
      rsp1_code_q  <= rsp1_code_d;
    end
  end

  // Gating with rst keeps a write from landing at the reset edge mid-access.
  assign mem_rw      = (state_q == ACCESS) & lat_rw_q & ~rst;
  assign mem_funct3  = lat_f3_q;
  assign mem_address = lat_addr_q;
  assign mem_wdata   = lat_wdata_q;

  assign rsp0_valid    = rsp0_valid_q;
  assign rsp0_rdata    = rsp0_rdata_q;
  assign rsp0_err      = rsp0_err_q;
  assign rsp0_err_code = rsp0_code_q;
  assign rsp1_valid    = rsp1_valid_q;
  assign rsp1_rdata    = rsp1_rdata_q;
  assign rsp1_err      = rsp1_err_q;
  assign rsp1_err_code = rsp1_code_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a byte-addressed memory model.
`timescale 1ns/1ps
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_rw, req1_valid, req1_ready, req1_rw;
  logic [2:0]  req0_funct3, req1_funct3;
  logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
  logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic [3:0]  rsp0_err_code, rsp1_err_code;
  logic        mem_rw;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_address, mem_wdata, mem_rdata;

  logic [7:0]  mem [256];
  logic        mem_clr;
  int          n_cmp = 0;
  int          n_mis = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rw(req0_rw),
    .req0_funct3(req0_funct3), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rw(req1_rw),
    .req1_funct3(req1_funct3), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .rsp0_err_code(rsp0_err_code),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .rsp1_err_code(rsp1_err_code),
    .mem_rw(mem_rw), .mem_funct3(mem_funct3), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Little-endian memory: combinational sized read, posedge sized write.
  always_comb begin
    logic [7:0] a;
    a = mem_address[7:0];
    case (mem_funct3)
      3'b000:  mem_rdata = {{24{mem[a][7]}}, mem[a]};
      3'b001:  mem_rdata = {{16{mem[a+8'd1][7]}}, mem[a+8'd1], mem[a]};
      3'b010:  mem_rdata = {mem[a+8'd3], mem[a+8'd2], mem[a+8'd1], mem[a]};
      3'b100:  mem_rdata = {24'd0, mem[a]};
      3'b101:  mem_rdata = {16'd0, mem[a+8'd1], mem[a]};
      default: mem_rdata = 32'd0;
    endcase
  end

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'd0;
    end else if (mem_rw) begin
      case (mem_funct3)
        3'b000: mem[mem_address[7:0]] <= mem_wdata[7:0];
        3'b001: begin
          mem[mem_address[7:0]]       <= mem_wdata[7:0];
          mem[mem_address[7:0]+8'd1]  <= mem_wdata[15:8];
        end
        3'b010: begin
          mem[mem_address[7:0]]       <= mem_wdata[7:0];
          mem[mem_address[7:0]+8'd1]  <= mem_wdata[15:8];
          mem[mem_address[7:0]+8'd2]  <= mem_wdata[23:16];
          mem[mem_address[7:0]+8'd3]  <= mem_wdata[31:24];
        end
        default: ;
      endcase
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int port, input logic v, input logic rw, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata);
    if (port == 0) begin
      req0_valid = v; req0_rw = rw; req0_funct3 = f3; req0_addr = addr; req0_wdata = wdata;
    end else begin
      req1_valid = v; req1_rw = rw; req1_funct3 = f3; req1_addr = addr; req1_wdata = wdata;
    end
  endtask

  // One request on one port; checks acceptance, latency, payload and write count.
  task automatic xact(input string tag, input int port, input logic rw, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err,
                      input logic [3:0] exp_code, input int exp_lat);
    int got;
    int lat;
    int wr;
    set_req(port, 1'b1, rw, f3, addr, wdata);
    got = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      @(negedge clk);
      if ((port == 0) ? req0_ready : req1_ready) got = 1;
      else begin @(posedge clk); #1; end
    end
    check_val({tag, "_accept"}, 32'(got), 32'd1);
    @(posedge clk); #1;
    set_req(port, 1'b0, rw, f3, addr, wdata);
    got = 0; lat = 0; wr = 0;
    for (int i = 1; i <= 8 && got == 0; i++) begin
      @(negedge clk);
      if (mem_rw) wr++;
      if ((port == 0) ? rsp0_valid : rsp1_valid) begin
        got = 1;
        lat = i;
        check_val({tag, "_other_rsp"}, 32'((port == 0) ? rsp1_valid : rsp0_valid), 32'd0);
        check_val({tag, "_rdata"}, (port == 0) ? rsp0_rdata : rsp1_rdata, exp_rdata);
        check_val({tag, "_err"}, 32'((port == 0) ? rsp0_err : rsp1_err), 32'(exp_err));
        check_val({tag, "_code"}, 32'((port == 0) ? rsp0_err_code : rsp1_err_code),
                  32'(exp_code));
      end
      @(posedge clk); #1;
    end
    check_val({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check_val({tag, "_mem_rw_cycles"}, 32'(wr), 32'((!exp_err && rw) ? 1 : 0));
  endtask

  initial begin
    int seq[$];
    int gcyc[$];
    int exp_seq[10];
    int cyc;
    int pulses;

    rst = 1'b1; mem_clr = 1'b1;
    set_req(0, 1'b1, 1'b0, 3'b010, 32'h0, 32'h0);
    set_req(1, 1'b1, 1'b0, 3'b010, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_ready0", 32'(req0_ready), 32'd0);
    check_val("rst_ready1", 32'(req1_ready), 32'd0);
    check_val("rst_mem_rw", 32'(mem_rw), 32'd0);
    check_val("rst_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 32'd0);
    check_val("rst_mem_addr", mem_address, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; mem_clr = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;

    xact("sw_p0",      0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 4'd0, 2);
    xact("lw_p0",      0, 1'b0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 4'd0, 2);
    xact("lh_mis_p0",  0, 1'b0, 3'b001, 32'h13, 32'h0,        32'h0,        1'b1, 4'd0, 1);
    xact("sw_mis_p1",  1, 1'b1, 3'b010, 32'h22, 32'h11223344, 32'h0,        1'b1, 4'd1, 1);
    xact("st_ill_p0",  0, 1'b1, 3'b100, 32'h40, 32'h55667788, 32'h0,        1'b1, 4'd2, 1);
    xact("ld_ill_p1",  1, 1'b0, 3'b011, 32'h40, 32'h0,        32'h0,        1'b1, 4'd2, 1);
    xact("lw_mis_p0",  0, 1'b0, 3'b010, 32'h12, 32'h0,        32'h0,        1'b1, 4'd0, 1);
    xact("sb_p1",      1, 1'b1, 3'b000, 32'h41, 32'h00000080, 32'h0,        1'b0, 4'd0, 2);
    xact("lb_p1",      1, 1'b0, 3'b000, 32'h41, 32'h0,        32'hFFFFFF80, 1'b0, 4'd0, 2);
    xact("lbu_p1",     1, 1'b0, 3'b100, 32'h41, 32'h0,        32'h00000080, 1'b0, 4'd0, 2);

    // Both ports continuously valid: record grant order.
    set_req(0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    set_req(1, 1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
    cyc = 0;
    while (seq.size() < 10 && cyc < 200) begin
      @(negedge clk);
      if (req0_ready && req1_ready) check_val("both_ready", 32'd1, 32'd0);
      if (req0_ready) seq.push_back(0);
      else if (req1_ready) seq.push_back(1);
      if (rsp0_valid) check_val("arb_rsp0_rdata", rsp0_rdata, 32'hDEADBEEF);
      if (rsp1_valid) check_val("arb_rsp1_rdata", rsp1_rdata, 32'h00008000);
      @(posedge clk); #1;
      cyc++;
      if (seq.size() == 10) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
      end
    end
    repeat (4) begin
      @(negedge clk);
      if (rsp0_valid) check_val("arb_rsp0_rdata", rsp0_rdata, 32'hDEADBEEF);
      if (rsp1_valid) check_val("arb_rsp1_rdata", rsp1_rdata, 32'h00008000);
      @(posedge clk); #1;
    end
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    exp_seq = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`else
    exp_seq = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
`endif
    check_val("arb_grant_count", 32'(seq.size()), 32'd10);
    for (int i = 0; i < 10; i++) begin
      check_val($sformatf("arb_grant_%0d", i), (i < seq.size()) ? 32'(seq[i]) : 32'hFFFFFFFF,
                32'(exp_seq[i]));
    end

    // Single valid port is granted in every accept slot.
    set_req(1, 1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
    cyc = 0;
    while (gcyc.size() < 3 && cyc < 50) begin
      @(negedge clk);
      if (req1_ready) gcyc.push_back(cyc);
      @(posedge clk); #1;
      cyc++;
      if (gcyc.size() == 3) req1_valid = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_val("single_grants", 32'(gcyc.size()), 32'd3);
    if (gcyc.size() == 3) begin
      check_val("single_gap_a", 32'(gcyc[1] - gcyc[0]), 32'd3);
      check_val("single_gap_b", 32'(gcyc[2] - gcyc[1]), 32'd3);
    end

    // Reset asserted during the ACCESS cycle of a store.
    set_req(0, 1'b1, 1'b1, 3'b010, 32'h30, 32'h12345678);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (!req0_ready) begin @(posedge clk); #1; end
    end while (!req0_ready && cyc < 20);
    check_val("rst_mid_accept", 32'(req0_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    req1_valid = 1'b1;
    @(negedge clk);
    check_val("rst_mid_ready0", 32'(req0_ready), 32'd0);
    check_val("rst_mid_ready1", 32'(req1_ready), 32'd0);
    check_val("rst_mid_mem_rw", 32'(mem_rw), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp0_valid || rsp1_valid) pulses++;
      @(posedge clk); #1;
    end
    check_val("rst_mid_no_rsp", 32'(pulses), 32'd0);
    check_val("rst_mid_mem", {mem[8'h33], mem[8'h32], mem[8'h31], mem[8'h30]}, 32'd0);
    xact("lw_after_rst", 0, 1'b0, 3'b010, 32'h30, 32'h0, 32'h0, 1'b0, 4'd0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
